// File: rtl/a2d_round_robin_sched.sv
// Round-robin sequencer for the shared SPI A2D: issues battery/torque/brake
// conversions and steers each pipelined response to its channel register.
module a2d_round_robin_sched #(
  parameter logic [2:0]  BATT_CH    = 3'd0,
  parameter logic [2:0]  TORQ_CH    = 3'd1,
  parameter logic [2:0]  BRAKE_CH   = 3'd4,
  parameter int unsigned GAP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rsp,
  output logic [11:0] batt,
  output logic [11:0] torque,
  output logic [11:0] brake,
  output logic        batt_vld,
  output logic        torque_vld,
  output logic        brake_vld,
  output logic        round_done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spi_wrt_q, spi_wrt_d;
  logic [15:0]      spi_cmd_q, spi_cmd_d;
  logic [11:0]      batt_q, batt_d;
  logic [11:0]      torque_q, torque_d;
  logic [11:0]      brake_q, brake_d;
  logic             batt_vld_q, batt_vld_d;
  logic             torque_vld_q, torque_vld_d;
  logic             brake_vld_q, brake_vld_d;
  logic             round_done_q, round_done_d;

  // Slot 3 re-addresses the battery channel purely to clock out the brake result.
  function automatic logic [15:0] slot_cmd(input logic [1:0] slot);
    logic [2:0] ch;
    case (slot)
      2'd1:    ch = TORQ_CH;
      2'd2:    ch = BRAKE_CH;
      default: ch = BATT_CH;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    gap_d        = gap_q;
    spi_wrt_d    = 1'b0;
    spi_cmd_d    = spi_cmd_q;
    batt_d       = batt_q;
    torque_d     = torque_q;
    brake_d      = brake_q;
    batt_vld_d   = 1'b0;
    torque_vld_d = 1'b0;
    brake_vld_d  = 1'b0;
    round_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && (gap_q == '0)) begin
          state_d   = S_SEND;
          slot_d    = 2'd0;
          spi_wrt_d = 1'b1;
          spi_cmd_d = slot_cmd(2'd0);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (spi_done) begin
          // Response belongs to the previous slot's address; slot 0's is stale.
          case (slot_q)
            2'd1: begin
              batt_d     = spi_rsp[11:0];
              batt_vld_d = 1'b1;
            end
            2'd2: begin
              torque_d     = spi_rsp[11:0];
              torque_vld_d = 1'b1;
            end
            2'd3: begin
              brake_d     = spi_rsp[11:0];
              brake_vld_d = 1'b1;
            end
            default: begin
              batt_d = batt_q;
            end
          endcase

          if (slot_q == 2'd3) begin
            state_d      = S_GAP;
            gap_d        = GAP_LOAD;
            round_done_d = 1'b1;
          end else begin
            state_d   = S_SEND;
            slot_d    = slot_q + 2'd1;
            spi_wrt_d = 1'b1;
            spi_cmd_d = slot_cmd(slot_q + 2'd1);
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= 2'd0;
      gap_q        <= '0;
      spi_wrt_q    <= 1'b0;
      spi_cmd_q    <= 16'h0000;
      batt_q       <= 12'h000;
      torque_q     <= 12'h000;
      brake_q      <= 12'h000;
      batt_vld_q   <= 1'b0;
      torque_vld_q <= 1'b0;
      brake_vld_q  <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      gap_q        <= gap_d;
      spi_wrt_q    <= spi_wrt_d;
      spi_cmd_q    <= spi_cmd_d;
      batt_q       <= batt_d;
      torque_q     <= torque_d;
      brake_q      <= brake_d;
      batt_vld_q   <= batt_vld_d;
      torque_vld_q <= torque_vld_d;
      brake_vld_q  <= brake_vld_d;
      round_done_q <= round_done_d;
    end
  end

  assign spi_wrt    = spi_wrt_q;
  assign spi_cmd    = spi_cmd_q;
  assign batt       = batt_q;
  assign torque     = torque_q;
  assign brake      = brake_q;
  assign batt_vld   = batt_vld_q;
  assign torque_vld = torque_vld_q;
  assign brake_vld  = brake_vld_q;
  assign round_done = round_done_q;

endmodule
